// File: rtl/pac_input_ctrl_if.sv
// pac_input_ctrl_if
//   Groups the raw push-button inputs and the conditioned movement request
//   of pac_input_ctrl into one bundle.
//   Signals:
//     btn_up/btn_down/btn_left/btn_right : raw asynchronous direction buttons, active-high
//     btn_center                         : raw asynchronous stop button, active-high
//     up/down/left/right                 : one-hot movement request to the sprite block
//     moving                             : high while a direction is being requested
//     press                              : one-cycle pulse on each accepted direction press
//   Modports:
//     master : button source / request consumer side (drives btn_*)
//     slave  : pac_input_ctrl side (drives the request outputs)
interface pac_input_ctrl_if;
   logic btn_up;
   logic btn_down;
   logic btn_left;
   logic btn_right;
   logic btn_center;
   logic up;
   logic down;
   logic left;
   logic right;
   logic moving;
   logic press;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_center,
      input  up, down, left, right, moving, press
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_center,
      output up, down, left, right, moving, press
   );
endinterface

// File: rtl/pac_input_ctrl.sv
// pac_input_ctrl
//   Button conditioning ahead of the Pac-Man sprite/collision block:
//   2-FF synchronisers, per-button debounce counters, rising-edge detection,
//   fixed press priority (up > right > left > down) and a one-hot registered
//   movement request.
//   Parameters:
//     DEBOUNCE_CNT : consecutive stable cycles needed to accept a level change (>= 2)
//     CNT_W        : debounce counter width, 2**CNT_W > DEBOUNCE_CNT
//   Ports:
//     clk : system clock
//     rst : synchronous reset, active-low
//     bus : pac_input_ctrl_if.slave (raw buttons in, up/down/left/right/moving/press out)
//   Configuration macro PAC_STICKY_DIR_EN:
//     defined   : the pressed direction stays latched until the next direction
//                 press; a centre press stops movement (centre beats a same-cycle
//                 direction press).
//     undefined : outputs follow the priority-encoded debounced direction levels;
//                 the centre button is not used.
module pac_input_ctrl #(
   parameter int unsigned DEBOUNCE_CNT = 500000,
   parameter int unsigned CNT_W        = 20
) (
   input logic             clk,
   input logic             rst,
   pac_input_ctrl_if.slave bus
);

`ifdef PAC_STICKY_DIR_EN
   localparam int unsigned NCH = 5;
`else
   localparam int unsigned NCH = 4;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_e;

   typedef enum logic {
      S_IDLE,
      S_MOVE
   } state_e;

   // Channel order follows the press priority: 0 up, 1 right, 2 left, 3 down, 4 centre.
   logic [NCH-1:0]   raw;
   logic [NCH-1:0]   sync1_q;
   logic [NCH-1:0]   sync2_q;
   logic [NCH-1:0]   db_q;
   logic [NCH-1:0]   db_prev_q;
   logic [NCH-1:0]   pr;
   logic [CNT_W-1:0] cnt_q [NCH];

   logic [3:0] sel_v;
   logic       sel_any;
   dir_e       dir_d;

   state_e state_q;
   dir_e   dir_q;
   logic   press_q;

`ifdef PAC_STICKY_DIR_EN
   assign raw = {bus.btn_center, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_up};
`else
   assign raw = {bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_up};
`endif

   // Synchronise, then debounce: the level flips on the DEBOUNCE_CNT-th
   // consecutive sample that disagrees with it; any agreeing sample restarts.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         db_prev_q <= db_q;
         for (int unsigned i = 0; i < NCH; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               db_q[i]  <= ~db_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign pr = db_q & ~db_prev_q;

   function automatic dir_e pick(input logic [3:0] v);
      if (v[0])      return DIR_UP;
      else if (v[1]) return DIR_RIGHT;
      else if (v[2]) return DIR_LEFT;
      else           return DIR_DOWN;
   endfunction

   // Sticky mode arbitrates between this cycle's presses; level mode
   // arbitrates between the currently held (debounced) directions.
   always_comb begin
`ifdef PAC_STICKY_DIR_EN
      sel_v = pr[3:0];
`else
      sel_v = db_q[3:0];
`endif
      sel_any = |sel_v;
      dir_d   = pick(sel_v);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         dir_q   <= DIR_UP;
         press_q <= 1'b0;
      end else begin
`ifdef PAC_STICKY_DIR_EN
         press_q <= 1'b0;
         if (pr[4]) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
         end else if (sel_any) begin
            state_q <= S_MOVE;
            dir_q   <= dir_d;
            press_q <= 1'b1;
         end
`else
         state_q <= sel_any ? S_MOVE : S_IDLE;
         dir_q   <= dir_d;
         // Only a rising edge on the direction actually driven counts as a press.
         press_q <= sel_any && pr[dir_d];
`endif
      end
   end

   // Decoding a single 2-bit direction keeps the request one-hot by construction.
   assign bus.up     = (state_q == S_MOVE) && (dir_q == DIR_UP);
   assign bus.right  = (state_q == S_MOVE) && (dir_q == DIR_RIGHT);
   assign bus.left   = (state_q == S_MOVE) && (dir_q == DIR_LEFT);
   assign bus.down   = (state_q == S_MOVE) && (dir_q == DIR_DOWN);
   assign bus.moving = (state_q == S_MOVE);
   assign bus.press  = press_q;

endmodule

// File: tb/tb_pac_input_ctrl.sv
module tb_pac_input_ctrl;

   localparam int unsigned D = 4;

`ifdef PAC_STICKY_DIR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic clk;
   logic rst;

   pac_input_ctrl_if bus ();

   pac_input_ctrl #(
      .DEBOUNCE_CNT (D),
      .CNT_W        (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int cyc = 0;

   // Observed outputs in the order {up, down, left, right, moving, press}.
   logic [5:0] act;
   assign act = {bus.up, bus.down, bus.left, bus.right, bus.moving, bus.press};

   // ---------------- behavioural model ----------------
   // Buttons indexed by priority: 0 up, 1 right, 2 left, 3 down, 4 centre.
   bit [4:0] m_s1, m_s2, m_db, m_dbp, m_raw, m_pr;
   int       m_run [5];
   bit       m_mov;
   int       m_dir;
   bit       m_press;
   logic [5:0] exp_v;

   assign m_raw = {bus.btn_center, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_up};

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
         for (int i = 0; i < 5; i++) m_run[i] = 0;
         m_mov = 1'b0; m_dir = 0; m_press = 1'b0;
      end else begin
         m_pr = m_db & ~m_dbp;
         m_press = 1'b0;
         if (STICKY) begin
            if (m_pr[4]) m_mov = 1'b0;
            else begin
               for (int i = 0; i < 4; i++) begin
                  if (m_pr[i]) begin
                     m_mov = 1'b1; m_dir = i; m_press = 1'b1;
                     break;
                  end
               end
            end
         end else begin
            m_mov = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (m_db[i]) begin
                  m_mov = 1'b1; m_dir = i; m_press = m_pr[i];
                  break;
               end
            end
         end
         m_dbp = m_db;
         // A level is accepted after D consecutive synchronised samples disagree with it.
         for (int i = 0; i < 5; i++) begin
            if (m_s2[i] != m_db[i]) m_run[i] = m_run[i] + 1;
            else m_run[i] = 0;
            if (m_run[i] == int'(D)) begin
               m_db[i] = ~m_db[i];
               m_run[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = m_raw;
      end
      exp_v = {m_mov && m_dir == 0, m_mov && m_dir == 3, m_mov && m_dir == 2,
               m_mov && m_dir == 1, m_mov, m_press};
   end

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (act !== exp_v) begin
            bad++;
            $display("FAIL model cycle=%0d got=%b want=%b (up,down,left,right,moving,press)",
                     cyc, act, exp_v);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input logic [5:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b (up,down,left,right,moving,press)", name, act, want);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_dirs(input bit u, input bit d, input bit l, input bit r);
      bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
   endtask

   initial begin
      rst = 1'b0;
      set_dirs(0, 0, 0, 0);
      bus.btn_center = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;

      // Reset held with every direction button high.
      set_dirs(1, 1, 1, 1);
      wait_n(3);
      chk("reset_hold", 6'b000000);
      rst = 1'b1;
      wait_n(6);
      chk("reset_rel_e6", 6'b000000);
      wait_n(1);
      chk("reset_rel_e7", 6'b100011);
      wait_n(1);
      chk("reset_rel_e8", 6'b100010);
      set_dirs(0, 0, 0, 0);
      wait_n(12);
      chk("release_up", STICKY ? 6'b100010 : 6'b000000);

      // Bouncing left button, then held.
      bus.btn_left = 1; wait_n(2);
      bus.btn_left = 0; wait_n(2);
      bus.btn_left = 1; wait_n(2);
      bus.btn_left = 0; wait_n(2);
      bus.btn_left = 1;
      wait_n(6);
      chk("bounce_e6", STICKY ? 6'b100010 : 6'b000000);
      wait_n(1);
      chk("bounce_e7", 6'b001011);
      bus.btn_left = 0;
      wait_n(12);
      chk("bounce_rel", STICKY ? 6'b001010 : 6'b000000);

      // Right pressed and released, then down replaces it.
      bus.btn_right = 1; wait_n(10);
      bus.btn_right = 0; wait_n(12);
      chk("right_rel", STICKY ? 6'b000110 : 6'b000000);
      bus.btn_down = 1;
      wait_n(6);
      chk("down_e6", STICKY ? 6'b000110 : 6'b000000);
      wait_n(1);
      chk("down_e7", 6'b010011);
      wait_n(1);
      chk("down_e8", 6'b010010);
      bus.btn_down = 0;
      wait_n(12);

      // Up and down raised together: up wins.
      set_dirs(1, 1, 0, 0);
      wait_n(7);
      chk("updown_e7", 6'b100011);
      wait_n(1);
      chk("updown_e8", 6'b100010);
      set_dirs(0, 0, 0, 0);
      wait_n(12);

      // Centre and left raised together while moving.
      bus.btn_center = 1; bus.btn_left = 1;
      wait_n(6);
      chk("ctr_left_e6", STICKY ? 6'b100010 : 6'b000000);
      wait_n(1);
      chk("ctr_left_e7", STICKY ? 6'b000000 : 6'b001011);
      wait_n(1);
      chk("ctr_left_e8", STICKY ? 6'b000000 : 6'b001010);
      bus.btn_center = 0; bus.btn_left = 0;
      wait_n(12);

      // Reset while moving left with the right press half counted.
      bus.btn_left = 1; wait_n(10);
      bus.btn_right = 1;
      wait_n(4);
      rst = 1'b0;
      wait_n(1);
      chk("midrst", 6'b000000);
      rst = 1'b1;
      wait_n(6);
      chk("midrst_e6", 6'b000000);
      wait_n(1);
      chk("midrst_e7", 6'b000111);
      set_dirs(0, 0, 0, 0);
      wait_n(12);

      // Left held then released, then centre pressed.
      bus.btn_left = 1;
      wait_n(7);
      chk("left_e7", 6'b001011);
      wait_n(5);
      bus.btn_left = 0;
      wait_n(6);
      chk("left_rel_e6", 6'b001010);
      wait_n(1);
      chk("left_rel_e7", STICKY ? 6'b001010 : 6'b000000);
      bus.btn_center = 1;
      wait_n(7);
      chk("center_e7", 6'b000000);
      bus.btn_center = 0;
      wait_n(10);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pac_input_ctrl.md
# pac_input_ctrl

Button conditioning stage directly upstream of the Pac-Man sprite/collision block. It synchronises and debounces the four raw direction push-buttons and the centre (stop) button. It converts presses into a single held, one-hot movement request (`up`/`down`/`left`/`right`) that the sprite block consumes every clock. It replaces the ad-hoc edge detectors previously sketched inside the sprite block.

## Interface

Parameters:
- `DEBOUNCE_CNT`, default 500000: consecutive stable cycles required to accept a level change (5 ms at 100 MHz); must be ≥ 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CNT.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw asynchronous direction buttons, active-high.
- `btn_center`  in  1  raw asynchronous stop button, active-high.
- `up`, `down`, `left`, `right`  out  1 each  movement request to the sprite block; at most one high.
- `moving`  out  1  high in MOVE state.
- `press`  out  1  one-cycle pulse on every accepted direction press.

## Operation

- **Synchroniser.** Each of the 5 raw inputs passes through a 2-FF synchroniser.
- **Debounce.** Each synchronised input has its own CNT_W-bit counter and a debounced level `db_*`.
  - If sync ≠ db, the counter increments.
  - If sync = db, the counter clears to 0.
  - When the counter equals DEBOUNCE_CNT−1 while sync ≠ db, db toggles and the counter clears on the same edge.
  - Any bounce back to the db value restarts the count from 0.
- **Edge detect.** A rise of `db_X` produces an internal one-cycle `pr_X`. Falls are ignored.
- **Press priority.** When several `pr_*` occur in the same cycle: up > right > left > down. This matches the sprite block's own priority. Lower-priority presses that cycle are discarded.
- **FSM states:** IDLE, MOVE.
  - IDLE: all direction outputs 0, `moving`=0. Any accepted direction press → MOVE, latching that direction.
  - MOVE: the latched direction is driven high. A new accepted direction press replaces the latch, including the opposite direction or the same direction. A rise of `db_center` → IDLE and clears the latch.
  - If a `db_center` rise and a direction press occur in the same cycle, centre wins → IDLE.
- **`press`** is high in the cycle the latch is written, whether entering MOVE or replacing a direction in MOVE. It is not asserted for a press lost to priority or overridden by centre.
- **Output width rule.** Outputs are decoded from a 2-bit latched direction plus state, so more than one direction high is structurally impossible.

## Timing

- **Reset** (`rst`=0 at a clk edge):
  - sync FFs, db levels, and counters → 0; FSM → IDLE.
  - `up`=`down`=`left`=`right`=0, `moving`=0, `press`=0.
  - Reset applied mid-count or in MOVE discards all state in one edge.
- **Latency.** A raw input that changes and then holds sees:
  - `db_X` change exactly DEBOUNCE_CNT+2 edges after the first sampling edge.
  - `press` and the direction/`moving` outputs update on the following edge (DEBOUNCE_CNT+3).
- **Output registration.** All outputs are registered. No combinational path runs from any `btn_*` to any output.
- **Holding a button** gives exactly one `press`. Releasing it has no effect on outputs.
- **Counter range.** Counters never exceed DEBOUNCE_CNT−1, so there is no wrap-around.

## Configuration

- Macro: `PAC_STICKY_DIR_EN`.
- **Defined:** behaviour as above. The direction stays latched after release until the next direction press or a centre press. This is arcade-style continuous movement.
- **Undefined:**
  - No latch. Outputs are the priority-encoded (up > right > left > down) one-hot of the current `db_*` levels, registered once.
  - `moving` = any output high. `btn_center` is ignored.
  - `press` still pulses on each accepted rising edge that wins priority.
  - Latency is unchanged.

## Test plan

Run with DEBOUNCE_CNT=4, `PAC_STICKY_DIR_EN` defined unless noted.

- **Reset.** Hold `rst`=0 for 3 cycles with all buttons high → all outputs 0. Release → `up`=1 and `press` pulse exactly 7 edges later.
- **Bounce.** Toggle `btn_left` 1,0,1,0 every 2 cycles, then hold 1 → no output until 7 edges after the final rise. Then `left`=1, one `press`.
- **Sticky and replace.** Press `right` then release → `right` stays 1. Press `down` → `right`=0 and `down`=1 on the same edge, `press`=1 for one cycle.
- **Simultaneous.** Raise `btn_up` and `btn_down` on the same edge → `up`=1 only, single `press`. Raise `btn_center` and `btn_left` together while in MOVE → IDLE, all outputs 0, no `press`.
- **Mid-operation reset.** In MOVE(`left`) with `btn_right` counter at 2, assert `rst`=0 for 1 cycle → all outputs 0. The pending right press needs a full 7 edges after `rst` deasserts.
- **Macro undefined.** Hold `btn_left` → `left`=1. Release → `left`=0 after 7 edges. Assert `btn_center` → no effect.
